// File: rtl/sys_control_ms.sv
// sys_control_ms: pipeline controller for the camera/filter datapath.
// Kicks off camera configuration (with retry on timeout) and owns the display mode,
// the per-stage filter enables, the Sobel threshold and the pipeline flush.
// Mode and stage-enable changes are staged to the next frame start and followed by a timed flush.
// Ports:
//   i_sysclk, db_rstn        clock, async active-low reset
//   i_sof                    start-of-frame pulse (i_sysclk domain)
//   i_cfg_done               camera configuration complete (level)
//   i_btn_mode/inc/dec       async push buttons (synchronised + debounced)
//   i_sw_stage, i_sw_freeze  async switches (synchronised)
//   o_cfg_start              1-cycle configuration request
//   o_mode, o_stage_en       active display mode / stage enables
//   o_pipe_flush             pipeline flush
//   o_threshold, o_thr_bound Sobel threshold and saturation flag
//   o_busy                   controller not in RUN
module sys_control_ms #(
    parameter int unsigned      N_STAGES     = 2,
    parameter int unsigned      THR_W        = 26,
    parameter logic [THR_W-1:0] THR_INIT     = THR_W'(4000),
    parameter logic [THR_W-1:0] THR_STEP     = THR_W'(500),
    parameter logic [THR_W-1:0] THR_MIN      = THR_W'(500),
    parameter logic [THR_W-1:0] THR_MAX      = THR_W'(20000),
    parameter int unsigned      DB_CYCLES    = 50000,
    parameter int unsigned      FLUSH_CYCLES = 8,
    parameter int unsigned      CFG_TIMEOUT  = 10000000
) (
    input  logic                i_sysclk,
    input  logic                db_rstn,
    input  logic                i_sof,
    input  logic                i_cfg_done,
    input  logic                i_btn_mode,
    input  logic                i_btn_inc,
    input  logic                i_btn_dec,
    input  logic [N_STAGES-1:0] i_sw_stage,
    input  logic                i_sw_freeze,
    output logic                o_cfg_start,
    output logic                o_mode,
    output logic [N_STAGES-1:0] o_stage_en,
    output logic                o_pipe_flush,
    output logic [THR_W-1:0]    o_threshold,
    output logic                o_thr_bound,
    output logic                o_busy
);

    localparam int unsigned N_BTN    = 3;
    localparam int unsigned SYNC_W   = N_BTN + N_STAGES + 1;
    localparam int unsigned DB_CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned FL_CNT_W = $clog2(FLUSH_CYCLES + 1);
    localparam int unsigned TMO_W    = (CFG_TIMEOUT > 1) ? $clog2(CFG_TIMEOUT) : 1;
    localparam logic        BOUND_INIT = (THR_INIT == THR_MIN) || (THR_INIT == THR_MAX);

    typedef enum logic [2:0] {
        S_INIT, S_CFG, S_ARM, S_APPLY, S_FLUSH, S_RUN
    } state_t;

    // Two-flop synchroniser for every asynchronous input
    logic [SYNC_W-1:0]   sync_q1, sync_q2;
    logic [N_BTN-1:0]    btn_s;
    logic [N_STAGES-1:0] sw_stage_s;
    logic                freeze_s;

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= {i_sw_freeze, i_sw_stage, i_btn_dec, i_btn_inc, i_btn_mode};
            sync_q2 <= sync_q1;
        end
    end

    assign btn_s      = sync_q2[N_BTN-1:0];
    assign sw_stage_s = sync_q2[N_BTN +: N_STAGES];
    assign freeze_s   = sync_q2[SYNC_W-1];

    // Debounce: level follows the input after DB_CYCLES consecutive differing samples;
    // a 0->1 transition of the level yields a one-cycle press event
    logic [N_BTN-1:0]    btn_db, btn_ev;
    logic [DB_CNT_W-1:0] db_cnt [N_BTN];

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            btn_db <= '0;
            btn_ev <= '0;
            for (int i = 0; i < N_BTN; i++) db_cnt[i] <= '0;
        end else begin
            btn_ev <= '0;
            for (int i = 0; i < N_BTN; i++) begin
                if (btn_s[i] == btn_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_CNT_W'(DB_CYCLES - 1)) begin
                    db_cnt[i] <= '0;
                    btn_db[i] <= btn_s[i];
                    btn_ev[i] <= btn_s[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_CNT_W'(1);
                end
            end
        end
    end

    // Threshold: saturating step computed one bit wider so it cannot wrap
    logic [THR_W:0]   thr_up, thr_dn;
    logic [THR_W-1:0] thr_nx;

    always_comb begin
        thr_up = {1'b0, o_threshold} + {1'b0, THR_STEP};
        thr_dn = {1'b0, o_threshold} - {1'b0, THR_STEP};
        thr_nx = o_threshold;
        if (btn_ev[1] && !btn_ev[2]) begin
            thr_nx = (thr_up > {1'b0, THR_MAX}) ? THR_MAX : thr_up[THR_W-1:0];
        end else if (btn_ev[2] && !btn_ev[1]) begin
            thr_nx = (thr_dn[THR_W] || (thr_dn < {1'b0, THR_MIN})) ? THR_MIN : thr_dn[THR_W-1:0];
        end
    end

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            o_threshold <= THR_INIT;
            o_thr_bound <= BOUND_INIT;
        end else begin
            o_threshold <= thr_nx;
            o_thr_bound <= (thr_nx == THR_MIN) || (thr_nx == THR_MAX);
        end
    end

    // Pending display mode; presses count only once configuration is done
    state_t state, state_nx;
    logic   pend_mode;

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            pend_mode <= 1'b0;
        end else if (btn_ev[0] && (state != S_INIT) && (state != S_CFG)) begin
            pend_mode <= ~pend_mode;
        end
    end

    // cfg_ok marks that a first apply happened; before that S_ARM may not cancel to RUN
    logic                cfg_start_nx, mode_nx, flush_nx, busy_nx, cfg_ok, cfg_ok_nx, changed;
    logic [N_STAGES-1:0] en_nx;
    logic [TMO_W-1:0]    tmo_cnt, tmo_nx;
    logic [FL_CNT_W-1:0] fl_cnt, fl_nx;

    assign changed = (pend_mode != o_mode) || (sw_stage_s != o_stage_en);

    always_ff @(posedge i_sysclk or negedge db_rstn) begin
        if (!db_rstn) begin
            state        <= S_INIT;
            o_cfg_start  <= 1'b0;
            o_mode       <= 1'b0;
            o_stage_en   <= '0;
            o_pipe_flush <= 1'b1;
            o_busy       <= 1'b1;
            cfg_ok       <= 1'b0;
            tmo_cnt      <= '0;
            fl_cnt       <= '0;
        end else begin
            state        <= state_nx;
            o_cfg_start  <= cfg_start_nx;
            o_mode       <= mode_nx;
            o_stage_en   <= en_nx;
            o_pipe_flush <= flush_nx;
            o_busy       <= busy_nx;
            cfg_ok       <= cfg_ok_nx;
            tmo_cnt      <= tmo_nx;
            fl_cnt       <= fl_nx;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nx     = state;
        cfg_start_nx = 1'b0;
        mode_nx      = o_mode;
        en_nx        = o_stage_en;
        flush_nx     = o_pipe_flush;
        cfg_ok_nx    = cfg_ok;
        tmo_nx       = tmo_cnt;
        fl_nx        = fl_cnt;
        case (state)
            S_INIT: begin
                state_nx     = S_CFG;
                cfg_start_nx = 1'b1;
                flush_nx     = 1'b1;
                tmo_nx       = '0;
            end
            S_CFG: begin
                flush_nx = 1'b1;
                if (i_cfg_done) begin
                    state_nx = S_ARM;
                    tmo_nx   = '0;
                end else if (tmo_cnt == TMO_W'(CFG_TIMEOUT - 1)) begin
                    cfg_start_nx = 1'b1;
                    tmo_nx       = '0;
                end else begin
                    tmo_nx = tmo_cnt + TMO_W'(1);
                end
            end
            S_ARM: begin
                flush_nx = cfg_ok ? freeze_s : 1'b1;
                if (cfg_ok && !changed) begin
                    state_nx = S_RUN;
                end else if (i_sof) begin
                    state_nx = S_APPLY;
                end
            end
            S_APPLY: begin
                state_nx  = S_FLUSH;
                mode_nx   = pend_mode;
                en_nx     = sw_stage_s;
                flush_nx  = 1'b1;
                fl_nx     = FL_CNT_W'(FLUSH_CYCLES);
                cfg_ok_nx = 1'b1;
            end
            S_FLUSH: begin
                flush_nx = 1'b1;
                if (fl_cnt == FL_CNT_W'(1)) begin
                    state_nx = S_RUN;
                    flush_nx = freeze_s;
                end else begin
                    fl_nx = fl_cnt - FL_CNT_W'(1);
                end
            end
            S_RUN: begin
                flush_nx = freeze_s;
                if (changed) state_nx = S_ARM;
            end
            default: state_nx = S_INIT;
        endcase
        busy_nx = (state_nx != S_RUN);
    end

endmodule

// File: tb/tb_sys_control_ms.sv
// tb_sys_control_ms: directed self-checking bench for sys_control_ms
// (DB_CYCLES=4, FLUSH_CYCLES=8, CFG_TIMEOUT=100, THR_INIT=19800).
module tb_sys_control_ms;

    localparam int unsigned N_STAGES = 2;
    localparam int unsigned THR_W    = 26;

    logic                i_sysclk    = 1'b0;
    logic                db_rstn     = 1'b0;
    logic                i_sof       = 1'b0;
    logic                i_cfg_done  = 1'b0;
    logic [2:0]          btn         = 3'b000;
    logic [N_STAGES-1:0] i_sw_stage  = 2'b10;
    logic                i_sw_freeze = 1'b0;
    logic                o_cfg_start, o_mode, o_pipe_flush, o_thr_bound, o_busy;
    logic [N_STAGES-1:0] o_stage_en;
    logic [THR_W-1:0]    o_threshold;

    int checks = 0;
    int errors = 0;

    sys_control_ms #(
        .N_STAGES(N_STAGES), .THR_W(THR_W),
        .THR_INIT(26'd19800), .THR_STEP(26'd500), .THR_MIN(26'd500), .THR_MAX(26'd20000),
        .DB_CYCLES(4), .FLUSH_CYCLES(8), .CFG_TIMEOUT(100)
    ) dut (
        .i_sysclk(i_sysclk), .db_rstn(db_rstn), .i_sof(i_sof), .i_cfg_done(i_cfg_done),
        .i_btn_mode(btn[0]), .i_btn_inc(btn[1]), .i_btn_dec(btn[2]),
        .i_sw_stage(i_sw_stage), .i_sw_freeze(i_sw_freeze),
        .o_cfg_start(o_cfg_start), .o_mode(o_mode), .o_stage_en(o_stage_en),
        .o_pipe_flush(o_pipe_flush), .o_threshold(o_threshold), .o_thr_bound(o_thr_bound),
        .o_busy(o_busy)
    );

    always #5 i_sysclk = ~i_sysclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic step();
        @(negedge i_sysclk);
    endtask

    task automatic press(input int idx, input int hold);
        btn[idx] = 1'b1;
        repeat (hold) step();
        btn[idx] = 1'b0;
        repeat (8) step();
    endtask

    // Snapshot of all outputs against their reset values
    task automatic check_reset_values(input string name, input logic [THR_W-1:0] thr);
        checks++;
        if ({o_cfg_start, o_mode, o_stage_en, o_pipe_flush, o_thr_bound, o_busy} !== 7'b0_0_00_1_0_1) begin
            errors++;
            $display("FAIL %s_ctrl: got start=%0b mode=%0b en=%b flush=%0b bound=%0b busy=%0b want 0 0 00 1 0 1",
                     name, o_cfg_start, o_mode, o_stage_en, o_pipe_flush, o_thr_bound, o_busy);
        end
        checks++;
        if (o_threshold !== thr) begin
            errors++;
            $display("FAIL %s_thr: got %0d want %0d", name, o_threshold, thr);
        end
    endtask

    // SOF in S_ARM: apply registers mode/enables, flush high exactly 8 cycles, then RUN
    task automatic test_frame_apply(input string name, input logic exp_mode, input logic [1:0] exp_en);
        int hi;
        i_sof = 1'b1;
        step();
        i_sof = 1'b0;
        step();
        checks++;
        if (o_mode !== exp_mode || o_stage_en !== exp_en || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_apply: got mode=%0b en=%b busy=%0b want mode=%0b en=%b busy=1",
                     name, o_mode, o_stage_en, o_busy, exp_mode, exp_en);
        end
        hi = int'(o_pipe_flush);
        for (int k = 2; k <= 8; k++) begin
            step();
            hi += int'(o_pipe_flush);
        end
        checks++;
        if (hi != 8) begin
            errors++;
            $display("FAIL %s_flush_len: got %0d high cycles want 8", name, hi);
        end
        step();
        checks++;
        if (o_pipe_flush !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_run: got flush=%0b busy=%0b want 0 0", name, o_pipe_flush, o_busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) step();
        check_reset_values("reset", 26'd19800);
    endtask

    task automatic test_cfg();
        int ones;
        db_rstn = 1'b1;
        step();
        checks++;
        if (o_cfg_start !== 1'b1) begin
            errors++;
            $display("FAIL cfg_pulse: got %0b want 1", o_cfg_start);
        end
        ones = 0;
        for (int k = 2; k <= 100; k++) begin
            step();
            ones += int'(o_cfg_start);
        end
        checks++;
        if (ones != 0) begin
            errors++;
            $display("FAIL cfg_quiet: got %0d start cycles want 0", ones);
        end
        step();
        checks++;
        if (o_cfg_start !== 1'b1) begin
            errors++;
            $display("FAIL cfg_retry: got %0b want 1", o_cfg_start);
        end
        step();
        checks++;
        if (o_cfg_start !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL cfg_retry_end: got start=%0b busy=%0b want 0 1", o_cfg_start, o_busy);
        end
        i_cfg_done = 1'b1;
        step();
        test_frame_apply("init", 1'b0, 2'b10);
    endtask

    task automatic test_mode();
        int bad;
        press(0, 8);
        checks++;
        if (o_busy !== 1'b1 || o_mode !== 1'b0) begin
            errors++;
            $display("FAIL mode_armed: got busy=%0b mode=%0b want 1 0", o_busy, o_mode);
        end
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (o_mode !== 1'b0 || o_pipe_flush !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mode_wait: got %0d cycles with mode/flush changed want 0", bad);
        end
        test_frame_apply("mode", 1'b1, 2'b10);
    endtask

    task automatic test_double_press();
        int hi;
        press(0, 8);
        press(0, 8);
        checks++;
        if (o_busy !== 1'b0 || o_mode !== 1'b1) begin
            errors++;
            $display("FAIL dbl_cancel: got busy=%0b mode=%0b want 0 1", o_busy, o_mode);
        end
        i_sof = 1'b1;
        step();
        i_sof = 1'b0;
        hi = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            hi += int'(o_pipe_flush) + int'(o_busy);
        end
        checks++;
        if (hi != 0 || o_mode !== 1'b1) begin
            errors++;
            $display("FAIL dbl_sof: got %0d flush/busy cycles mode=%0b want 0 1", hi, o_mode);
        end
    endtask

    task automatic test_debounce();
        btn[2] = 1'b1; step();
        btn[2] = 1'b0; step();
        btn[2] = 1'b1; step();
        btn[2] = 1'b0;
        repeat (12) step();
        checks++;
        if (o_threshold !== 26'd19800) begin
            errors++;
            $display("FAIL bounce: got %0d want 19800", o_threshold);
        end
        press(2, 12);
        checks++;
        if (o_threshold !== 26'd19300) begin
            errors++;
            $display("FAIL held_once: got %0d want 19300", o_threshold);
        end
    endtask

    task automatic test_threshold();
        btn[1] = 1'b1;
        repeat (6) step();
        checks++;
        if (o_threshold !== 26'd19300) begin
            errors++;
            $display("FAIL thr_early: got %0d want 19300", o_threshold);
        end
        step();
        checks++;
        if (o_threshold !== 26'd19800 || o_thr_bound !== 1'b0) begin
            errors++;
            $display("FAIL thr_latency: got %0d bound=%0b want 19800 0", o_threshold, o_thr_bound);
        end
        repeat (5) step();
        btn[1] = 1'b0;
        repeat (8) step();
        press(1, 8);
        press(1, 8);
        checks++;
        if (o_threshold !== 26'd20000 || o_thr_bound !== 1'b1) begin
            errors++;
            $display("FAIL thr_max: got %0d bound=%0b want 20000 1", o_threshold, o_thr_bound);
        end
        press(2, 8);
        checks++;
        if (o_threshold !== 26'd19500 || o_thr_bound !== 1'b0) begin
            errors++;
            $display("FAIL thr_dec: got %0d bound=%0b want 19500 0", o_threshold, o_thr_bound);
        end
        for (int k = 0; k < 38; k++) press(2, 8);
        checks++;
        if (o_threshold !== 26'd500 || o_thr_bound !== 1'b1) begin
            errors++;
            $display("FAIL thr_min: got %0d bound=%0b want 500 1", o_threshold, o_thr_bound);
        end
        press(2, 8);
        checks++;
        if (o_threshold !== 26'd500 || o_thr_bound !== 1'b1) begin
            errors++;
            $display("FAIL thr_min_sat: got %0d bound=%0b want 500 1", o_threshold, o_thr_bound);
        end
        press(1, 8);
        btn = 3'b110;
        repeat (8) step();
        btn = 3'b000;
        repeat (8) step();
        checks++;
        if (o_threshold !== 26'd1000 || o_thr_bound !== 1'b0) begin
            errors++;
            $display("FAIL thr_both: got %0d bound=%0b want 1000 0", o_threshold, o_thr_bound);
        end
    endtask

    task automatic test_freeze();
        i_sw_freeze = 1'b1;
        repeat (2) step();
        checks++;
        if (o_pipe_flush !== 1'b0) begin
            errors++;
            $display("FAIL freeze_sync: got %0b want 0", o_pipe_flush);
        end
        step();
        checks++;
        if (o_pipe_flush !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL freeze_on: got flush=%0b busy=%0b want 1 0", o_pipe_flush, o_busy);
        end
        i_sw_freeze = 1'b0;
        repeat (3) step();
        checks++;
        if (o_pipe_flush !== 1'b0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL freeze_off: got flush=%0b busy=%0b want 0 0", o_pipe_flush, o_busy);
        end
    endtask

    task automatic test_reset_in_flush();
        i_sw_stage = 2'b01;
        repeat (6) step();
        checks++;
        if (o_busy !== 1'b1 || o_stage_en !== 2'b10) begin
            errors++;
            $display("FAIL sw_armed: got busy=%0b en=%b want 1 10", o_busy, o_stage_en);
        end
        i_sof = 1'b1;
        step();
        i_sof = 1'b0;
        step();
        checks++;
        if (o_stage_en !== 2'b01 || o_mode !== 1'b1 || o_pipe_flush !== 1'b1) begin
            errors++;
            $display("FAIL sw_apply: got en=%b mode=%0b flush=%0b want 01 1 1", o_stage_en, o_mode, o_pipe_flush);
        end
        repeat (3) step();
        #2 db_rstn = 1'b0;
        #1 check_reset_values("midrst", 26'd19800);
        step();
        db_rstn = 1'b1;
        step();
        checks++;
        if (o_cfg_start !== 1'b1 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL restart_cfg: got start=%0b busy=%0b want 1 1", o_cfg_start, o_busy);
        end
        step();
        test_frame_apply("restart", 1'b0, 2'b01);
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_mode();
        test_double_press();
        test_debounce();
        test_threshold();
        test_freeze();
        test_reset_in_flush();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
